// File: rtl/vlane_wb_arbiter.sv
// Purpose : shares the lane's single VRF write port between the execution
//           writeback stream and a FIFO-buffered load-return stream.
// Latency : a beat granted in cycle N is on vrf_* with vrf_we=1 in cycle N+1.
// Backpr. : exec_ready drops only in cycles where a load wins the port;
//           load_ready drops only when the FIFO is full (no bypass when full).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   exec_valid/ready, exec_*    execution writeback request (dest/data/masked/sew)
//   load_valid/ready, load_*    load-return beat (dest/data/sew) into the FIFO
//   vrf_*                       registered register-file write port
//   load_pending                FIFO non-empty (combinational from occupancy)
//
// Optional feature: define VWB_STARVE_GUARD_EN to enable the starvation guard,
// which lets a waiting load win after STARVE_LIMIT consecutive execution wins.
// Without it execution always has priority and STARVE_LIMIT is ignored.

module vlane_wb_arbiter #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned LOAD_FIFO_DEPTH = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exec_valid,
    output logic                  exec_ready,
    input  logic [4:0]            exec_dest,
    input  logic [DATA_WIDTH-1:0] exec_data,
    input  logic                  exec_masked,
    input  logic [2:0]            exec_sew,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4:0]            load_dest,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [2:0]            load_sew,
    output logic                  vrf_we,
    output logic [4:0]            vrf_waddr,
    output logic [DATA_WIDTH-1:0] vrf_wdata,
    output logic                  vrf_masked,
    output logic [2:0]            vrf_sew,
    output logic                  vrf_from_load,
    output logic                  load_pending
);

    localparam int unsigned PW = (LOAD_FIFO_DEPTH > 1) ? $clog2(LOAD_FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(LOAD_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(LOAD_FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]            dest;
        logic [DATA_WIDTH-1:0] data;
        logic [2:0]            sew;
    } ld_beat_t;

    // ---------------- load-return FIFO ----------------
    ld_beat_t      fifo_q [LOAD_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic     fifo_full, fifo_nonempty, push, pop;
    logic     load_grant, exec_grant, starve_hit;
    ld_beat_t head;

    assign fifo_full     = (count_q == DEPTH_C);
    assign fifo_nonempty = (count_q != '0);
    // Fullness is judged on registered occupancy, so a pop in the same cycle
    // does not open a slot for an incoming beat.
    assign push          = load_valid && !fifo_full;
    assign pop           = load_grant;
    assign head          = fifo_q[rd_ptr_q];

    assign load_ready    = !fifo_full;
    assign load_pending  = fifo_nonempty;

    // ---------------- grant ----------------
    // fifo_nonempty comes from registered occupancy, so a beat pushed into an
    // empty FIFO cannot be granted until the following cycle.
    assign load_grant = fifo_nonempty && (!exec_valid || starve_hit);
    assign exec_grant = exec_valid && !load_grant;
    assign exec_ready = !load_grant;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{dest: load_dest, data: load_data, sew: load_sew};
        end
    end

    // ---------------- starvation guard ----------------
`ifdef VWB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;

    // Counts execution wins while a load waits; any load pop or an empty
    // FIFO restarts the count. Saturates so the load keeps winning if it
    // somehow cannot pop.
    always_comb begin
        starve_d = starve_q;
        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (exec_grant && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    assign starve_hit = (starve_q == LIMIT_C);
`else
    logic unused_starve_limit;
    assign unused_starve_limit = (STARVE_LIMIT != 0);
    assign starve_hit          = 1'b0;
`endif

    // ---------------- output register ----------------
    logic                  we_q,    we_d;
    logic [4:0]            waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  masked_q, masked_d;
    logic [2:0]            sew_q,   sew_d;
    logic                  fl_q,    fl_d;

    // Payload fields hold their last value on idle cycles; only we drops.
    always_comb begin
        we_d     = load_grant || exec_grant;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        masked_d = masked_q;
        sew_d    = sew_q;
        fl_d     = fl_q;
        if (load_grant) begin
            waddr_d  = head.dest;
            wdata_d  = head.data;
            masked_d = 1'b0;
            sew_d    = head.sew;
            fl_d     = 1'b1;
        end else if (exec_grant) begin
            waddr_d  = exec_dest;
            wdata_d  = exec_data;
            masked_d = exec_masked;
            sew_d    = exec_sew;
            fl_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            masked_q <= 1'b0;
            sew_q    <= '0;
            fl_q     <= 1'b0;
        end else begin
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            masked_q <= masked_d;
            sew_q    <= sew_d;
            fl_q     <= fl_d;
        end
    end

    assign vrf_we        = we_q;
    assign vrf_waddr     = waddr_q;
    assign vrf_wdata     = wdata_q;
    assign vrf_masked    = masked_q;
    assign vrf_sew       = sew_q;
    assign vrf_from_load = fl_q;

endmodule

// File: tb/tb_vlane_wb_arbiter.sv
// Purpose : directed, table-driven bench for vlane_wb_arbiter plus hand-written
//           multi-cycle sequences (FIFO full / starvation guard / reset mid-drain).
// Timing  : inputs driven 1ns after posedge, combinational outputs checked 1ns
//           later, registered outputs checked 1ns after the following posedge.

module tb_vlane_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exec_valid, exec_ready, exec_masked;
    logic [4:0]  exec_dest;
    logic [63:0] exec_data;
    logic [2:0]  exec_sew;
    logic        load_valid, load_ready;
    logic [4:0]  load_dest;
    logic [63:0] load_data;
    logic [2:0]  load_sew;
    logic        vrf_we, vrf_masked, vrf_from_load, load_pending;
    logic [4:0]  vrf_waddr;
    logic [63:0] vrf_wdata;
    logic [2:0]  vrf_sew;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vlane_wb_arbiter #(
        .DATA_WIDTH      (64),
        .LOAD_FIFO_DEPTH (4),
        .STARVE_LIMIT    (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .exec_valid    (exec_valid),
        .exec_ready    (exec_ready),
        .exec_dest     (exec_dest),
        .exec_data     (exec_data),
        .exec_masked   (exec_masked),
        .exec_sew      (exec_sew),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_dest     (load_dest),
        .load_data     (load_data),
        .load_sew      (load_sew),
        .vrf_we        (vrf_we),
        .vrf_waddr     (vrf_waddr),
        .vrf_wdata     (vrf_wdata),
        .vrf_masked    (vrf_masked),
        .vrf_sew       (vrf_sew),
        .vrf_from_load (vrf_from_load),
        .load_pending  (load_pending)
    );

    typedef struct {
        logic        ev;  logic [4:0] ed; logic [63:0] edat; logic em; logic [2:0] es;
        logic        lv;  logic [4:0] ld; logic [63:0] ldat; logic [2:0] ls;
        logic        xer; logic xlr; logic xpd;
        logic        xwe; logic [4:0] xa; logic [63:0] xd; logic xm; logic [2:0] xs; logic xfl;
    } vec_t;

    function automatic vec_t mk(
        input logic ev, input logic [4:0] ed, input logic [63:0] edat,
        input logic em, input logic [2:0] es,
        input logic lv, input logic [4:0] ld, input logic [63:0] ldat, input logic [2:0] ls,
        input logic xer, input logic xlr, input logic xpd,
        input logic xwe, input logic [4:0] xa, input logic [63:0] xd,
        input logic xm, input logic [2:0] xs, input logic xfl);
        vec_t v;
        v.ev = ev;   v.ed = ed;   v.edat = edat; v.em = em; v.es = es;
        v.lv = lv;   v.ld = ld;   v.ldat = ldat; v.ls = ls;
        v.xer = xer; v.xlr = xlr; v.xpd = xpd;
        v.xwe = xwe; v.xa = xa;   v.xd = xd;     v.xm = xm; v.xs = xs; v.xfl = xfl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exec(input logic v, input logic [4:0] d, input logic [63:0] dat,
                            input logic m, input logic [2:0] s);
        exec_valid = v; exec_dest = d; exec_data = dat; exec_masked = m; exec_sew = s;
    endtask

    task automatic set_load(input logic v, input logic [4:0] d, input logic [63:0] dat,
                            input logic [2:0] s);
        load_valid = v; load_dest = d; load_data = dat; load_sew = s;
    endtask

    task automatic chk_comb(input string tag, input logic er, input logic lr, input logic pd);
        #1;
        chk({tag, "_exec_ready"},   exec_ready,   er);
        chk({tag, "_load_ready"},   load_ready,   lr);
        chk({tag, "_load_pending"}, load_pending, pd);
    endtask

    task automatic chk_regs(input string tag, input logic we, input logic [4:0] a,
                            input logic [63:0] d, input logic m, input logic [2:0] s,
                            input logic fl);
        chk({tag, "_we"},        vrf_we,        we);
        chk({tag, "_waddr"},     vrf_waddr,     a);
        chk({tag, "_wdata"},     vrf_wdata,     d);
        chk({tag, "_masked"},    vrf_masked,    m);
        chk({tag, "_sew"},       vrf_sew,       s);
        chk({tag, "_from_load"}, vrf_from_load, fl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    vec_t vecs [13];

    initial begin
        // exec / load inputs | comb: exec_ready load_ready pending | regs after edge
        vecs[0]  = mk(0, 0,  0,     0, 0,  0, 0,  0,     0,  1, 1, 0,  0, 0,  0,     0, 0, 0);
        vecs[1]  = mk(1, 5,  'hA5,  1, 2,  0, 0,  0,     0,  1, 1, 0,  1, 5,  'hA5,  1, 2, 0);
        vecs[2]  = mk(0, 0,  0,     0, 0,  0, 0,  0,     0,  1, 1, 0,  0, 5,  'hA5,  1, 2, 0);
        vecs[3]  = mk(0, 0,  0,     0, 0,  1, 7,  'h70,  3,  1, 1, 0,  0, 5,  'hA5,  1, 2, 0);
        vecs[4]  = mk(0, 0,  0,     0, 0,  1, 8,  'h80,  3,  0, 1, 1,  1, 7,  'h70,  0, 3, 1);
        vecs[5]  = mk(0, 0,  0,     0, 0,  1, 9,  'h90,  3,  0, 1, 1,  1, 8,  'h80,  0, 3, 1);
        vecs[6]  = mk(0, 0,  0,     0, 0,  0, 0,  0,     0,  0, 1, 1,  1, 9,  'h90,  0, 3, 1);
        vecs[7]  = mk(0, 0,  0,     0, 0,  0, 0,  0,     0,  1, 1, 0,  0, 9,  'h90,  0, 3, 1);
        vecs[8]  = mk(1, 10, 'hB1,  0, 1,  1, 11, 'hC1,  0,  1, 1, 0,  1, 10, 'hB1,  0, 1, 0);
        vecs[9]  = mk(1, 12, 'hB2,  1, 0,  0, 0,  0,     0,  1, 1, 1,  1, 12, 'hB2,  1, 0, 0);
        vecs[10] = mk(0, 0,  0,     0, 0,  0, 0,  0,     0,  0, 1, 1,  1, 11, 'hC1,  0, 0, 1);
        vecs[11] = mk(1, 13, 'hB3,  0, 2,  0, 0,  0,     0,  1, 1, 0,  1, 13, 'hB3,  0, 2, 0);
        vecs[12] = mk(0, 0,  0,     0, 0,  0, 0,  0,     0,  1, 1, 0,  0, 13, 'hB3,  0, 2, 0);

        // ---- reset held for two cycles ----
        rst = 1'b1;
        set_exec(0, 0, 0, 0, 0);
        set_load(0, 0, 0, 0);
        repeat (2) step_edge();
        chk_regs("reset", 0, 0, 0, 0, 0, 0);
        chk("reset_load_pending", load_pending, 1'b0);
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int i = 0; i < 13; i++) begin
            set_exec(vecs[i].ev, vecs[i].ed, vecs[i].edat, vecs[i].em, vecs[i].es);
            set_load(vecs[i].lv, vecs[i].ld, vecs[i].ldat, vecs[i].ls);
            chk_comb($sformatf("v%0d", i), vecs[i].xer, vecs[i].xlr, vecs[i].xpd);
            step_edge();
            chk_regs($sformatf("v%0d", i), vecs[i].xwe, vecs[i].xa, vecs[i].xd,
                     vecs[i].xm, vecs[i].xs, vecs[i].xfl);
        end

`ifndef VWB_STARVE_GUARD_EN
        // ---- FIFO full with exec held high (fixed exec priority) ----
        for (int k = 0; k < 5; k++) begin
            set_exec(1, 5'(20 + k), 64'h200 + 64'(20 + k), 1, 1);
            set_load(1, 5'(16 + k), 64'h100 + 64'(16 + k), 3'(16 + k));
            // beat 5 (k=4) meets a full FIFO
            chk_comb($sformatf("full%0d", k), 1, (k < 4), (k > 0));
            step_edge();
            chk_regs($sformatf("full%0d", k), 1, 5'(20 + k), 64'h200 + 64'(20 + k), 1, 1, 0);
        end
        // drain; a beat offered in the first drain cycle must be refused
        set_exec(0, 0, 0, 0, 0);
        set_load(1, 30, 64'h130, 6);
        chk_comb("drain0", 0, 0, 1);
        step_edge();
        chk_regs("drain0", 1, 16, 64'h110, 0, 0, 1);
        set_load(0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            chk_comb($sformatf("drain%0d", k), 0, 1, 1);
            step_edge();
            chk_regs($sformatf("drain%0d", k), 1, 5'(16 + k), 64'h100 + 64'(16 + k),
                     0, 3'(16 + k), 1);
        end
        chk_comb("drain4", 1, 1, 0);
        step_edge();
        chk_regs("drain4", 0, 19, 64'h113, 0, 3, 1);
`else
        // ---- starvation guard: one load queued, exec continuous ----
        set_exec(1, 1, 64'h301, 1, 1);
        set_load(1, 25, 64'h425, 5);
        chk_comb("stv0", 1, 1, 0);
        step_edge();
        chk_regs("stv0", 1, 1, 64'h301, 1, 1, 0);
        set_load(0, 0, 0, 0);
        for (int k = 2; k <= 4; k++) begin
            set_exec(1, 5'(k), 64'h300 + 64'(k), 1, 1);
            chk_comb($sformatf("stv%0d", k - 1), 1, 1, 1);
            step_edge();
            chk_regs($sformatf("stv%0d", k - 1), 1, 5'(k), 64'h300 + 64'(k), 1, 1, 0);
        end
        set_exec(1, 5, 64'h305, 1, 1);
        chk_comb("stv4", 0, 1, 1);
        step_edge();
        chk_regs("stv4", 1, 25, 64'h425, 0, 5, 1);
        chk_comb("stv5", 1, 1, 0);
        step_edge();
        chk_regs("stv5", 1, 5, 64'h305, 1, 1, 0);
        set_exec(0, 0, 0, 0, 0);
        step_edge();
        chk_regs("stv6", 0, 5, 64'h305, 1, 1, 0);
`endif

        // ---- reset mid-drain with two beats buffered ----
        set_exec(1, 10, 64'h510, 0, 2);
        set_load(1, 26, 64'h626, 1);
        step_edge();
        chk_regs("rmd0", 1, 10, 64'h510, 0, 2, 0);
        set_exec(1, 11, 64'h511, 0, 2);
        set_load(1, 27, 64'h627, 1);
        chk_comb("rmd1", 1, 1, 1);
        step_edge();
        chk_regs("rmd1", 1, 11, 64'h511, 0, 2, 0);
        rst = 1'b1;
        set_exec(0, 0, 0, 0, 0);
        set_load(0, 0, 0, 0);
        step_edge();
        chk_regs("rmd2", 0, 0, 0, 0, 0, 0);
        chk("rmd2_load_pending", load_pending, 1'b0);
        rst = 1'b0;
        for (int k = 3; k < 5; k++) begin
            chk_comb($sformatf("rmd%0d", k), 1, 1, 0);
            step_edge();
            chk_regs($sformatf("rmd%0d", k), 0, 0, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
